uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one UART transmitter; legal range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 256: maximum cycles to wait for tx_busy to rise after tx_start.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 req  input  NUM_REQ  per-requester byte-send request, level, held until ack.
REQ-006 req_data  input  NUM_REQ*8  byte of requester k at bits [8k+7:8k].
REQ-007 ack  output  NUM_REQ  one-hot, one-cycle pulse: requester's byte accepted by transmitter.
REQ-008 tx_start  output  1  one-cycle start pulse to the shared uart_tx.
REQ-009 tx_data  output  8  byte presented to uart_tx; stable from tx_start until return to IDLE.
REQ-010 tx_busy  input  1  uart_tx busy flag, high while a frame is being shifted out.
REQ-011 active_id  output  clog2(NUM_REQ)  index of currently granted requester; 0 when IDLE.
REQ-012 timeout_err  output  1  sticky flag: a launched byte never raised tx_busy.

Function
REQ-013 FSM states SHALL be IDLE, START, WAIT_BUSY, WAIT_DONE; exactly one active.
REQ-014 IDLE: if any req bit high and tx_busy low, SHALL grant one requester, latch its req_data into tx_data and its index into active_id, go to START; otherwise stay in IDLE.
REQ-015 IDLE with tx_busy high (transmitter in use externally) SHALL not grant.
REQ-016 Grant SHALL be round-robin: search begins at pointer rr_ptr, ascending and wrapping modulo NUM_REQ; first set req bit wins.
REQ-017 START: tx_start SHALL be 1 for exactly this one cycle; next state WAIT_BUSY; wait counter cleared.
REQ-018 Latency: req sampled high in IDLE at edge n -> tx_start high during cycle n+1.
REQ-019 WAIT_BUSY: on tx_busy=1, ack[active_id] SHALL pulse for one cycle and state SHALL go to WAIT_DONE.
REQ-020 WAIT_BUSY: counter increments each cycle; when it reaches TIMEOUT_CYCLES-1 with tx_busy still 0, timeout_err SHALL set, no ack issued, state SHALL go to IDLE.
REQ-021 WAIT_DONE: on tx_busy=0 state SHALL go to IDLE; no new grant in that same cycle.
REQ-022 rr_ptr SHALL update to (active_id+1) mod NUM_REQ on leaving WAIT_DONE or on timeout; otherwise unchanged.
REQ-023 Requester dropping req after grant but before ack SHALL NOT abort the transfer; ack still pulses.
REQ-024 Changes on req_data after grant SHALL NOT affect tx_data.
REQ-025 Only one ack bit SHALL ever be high; ack never asserted outside the WAIT_BUSY->WAIT_DONE transition.
REQ-026 timeout_err SHALL remain 1 until reset; arbitration continues normally after it.
REQ-027 Simultaneous req from all requesters SHALL yield service order rr_ptr, rr_ptr+1, ... with no requester served twice before every other pending requester is served once.

Reset
REQ-028 rst=0 SHALL immediately, without clk, force state IDLE, rr_ptr=0, counter=0, tx_start=0, ack=0, tx_data=8'h00, active_id=0, timeout_err=0.
REQ-029 Reset asserted mid-transfer SHALL abandon it with no ack; after release, the pending requester is re-arbitrated from rr_ptr=0.
REQ-030 First grant SHALL occur no earlier than the first rising edge after rst returns to 1.

Verification
REQ-031 Single request: req=4'b0100, req_data[23:16]=8'h5A, tx_busy rises 2 cycles after tx_start, held 10 cycles -> tx_start one pulse, tx_data=8'h5A, ack=4'b0100 one pulse, active_id=2, back to IDLE.
REQ-032 Round robin: req=4'b1111 held, each with distinct byte (8'hA0..8'hA3) -> acks in order 0,1,2,3,0; tx_data sequence A0,A1,A2,A3,A0.
REQ-033 Timeout: req=4'b0001, tx_busy tied 0 -> timeout_err=1 exactly TIMEOUT_CYCLES cycles after tx_start, no ack, rr_ptr=1; then req=4'b0011 with working tx_busy -> requester 1 served first.
REQ-034 External busy: tx_busy=1 while req=4'b0010 in IDLE -> no tx_start until tx_busy=0, then tx_start next cycle.
REQ-035 Reset mid-frame: rst=0 during WAIT_DONE -> all outputs at reset values same cycle, no ack; after release, held req=4'b1000 is regranted.
REQ-036 Data stability: req_data changed from 8'h11 to 8'h22 one cycle after grant -> tx_data stays 8'h11 through WAIT_DONE.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter letting NUM_REQ requesters share one uart_tx,
// with a sticky timeout flag when a launched byte never raises tx_busy.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*8-1:0]       req_data_i,
    output logic [NUM_REQ-1:0]         ack_o,
    output logic                       tx_start_o,
    output logic [7:0]                 tx_data_o,
    input  logic                       tx_busy_i,
    output logic [$clog2(NUM_REQ)-1:0] active_id_o,
    output logic                       timeout_err_o
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  rr_ptr_q, rr_ptr_d, id_q, id_d, gnt_idx, cand, nxt_ptr;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     data_q, data_d;
    logic           err_q, err_d, gnt_vld;

    // Descending scan so the candidate closest to rr_ptr is the last one written.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IW'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (req_i[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign nxt_ptr = IW'((int'(id_q) + 1) % NUM_REQ);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        id_d       = id_q;
        err_d      = err_q;
        ack_o      = '0;
        tx_start_o = 1'b0;
        case (state_q)
            IDLE: if (gnt_vld && !tx_busy_i) begin
                state_d = START;
                data_d  = req_data_i[{gnt_idx, 3'b000} +: 8];
                id_d    = gnt_idx;
            end
            START: begin
                tx_start_o = 1'b1;
                cnt_d      = '0;
                state_d    = WAIT_BUSY;
            end
            WAIT_BUSY: if (tx_busy_i) begin
                ack_o[id_q] = 1'b1;
                state_d     = WAIT_DONE;
            end else if (cnt_q + 1'b1 == CW'(TIMEOUT_CYCLES - 1)) begin
                err_d    = 1'b1;
                state_d  = IDLE;
                rr_ptr_d = nxt_ptr;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            WAIT_DONE: if (!tx_busy_i) begin
                state_d  = IDLE;
                rr_ptr_d = nxt_ptr;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            data_q   <= 8'h00;
            id_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            id_q     <= id_d;
            err_q    <= err_d;
        end
    end

    assign tx_data_o     = data_q;
    assign active_id_o   = (state_q == IDLE) ? '0 : id_q;
    assign timeout_err_o = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenario tasks with inline checks against hand-computed values.
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int T = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N*8-1:0] req_data = '0;
    logic [N-1:0] ack;
    logic         tx_start;
    logic [7:0]   tx_data;
    logic         tx_busy = 1'b0;
    logic [1:0]   active_id;
    logic         timeout_err;
    int errors = 0;
    int checks = 0;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_data_i(req_data), .ack_o(ack),
        .tx_start_o(tx_start), .tx_data_o(tx_data), .tx_busy_i(tx_busy),
        .active_id_o(active_id), .timeout_err_o(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; req_data = '0; tx_busy = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Returns at the negedge of the cycle in which tx_start is high.
    task automatic wait_start(input string name);
        bit ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = (tx_start === 1'b1);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_start_timeout: tx_start=%b expected 1 within 50 cycles", name, tx_start);
        end
    endtask

    // One well-behaved transfer: busy rises the cycle after tx_start, lasts one cycle.
    task automatic serve(input string name, output logic [7:0] d, output logic [1:0] id, output logic [3:0] a);
        wait_start(name);
        d = tx_data;
        id = active_id;
        step();
        tx_busy = 1'b1;
        @(negedge clk);
        a = ack;
        step();
        tx_busy = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 4'b0001;
        req_data = 32'h0000_0077;
        #1;
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start: got %b exp 0", tx_start); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL rst_ack: got %b exp 0000", ack); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h exp 00", tx_data); end
        checks++; if (active_id !== 2'd0) begin errors++; $display("FAIL rst_active_id: got %0d exp 0", active_id); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err: got %b exp 0", timeout_err); end
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_early_grant: tx_start=%b exp 0", tx_start); end
        @(negedge clk);
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'h77) begin errors++; $display("FAIL rst_first_grant: tx_start=%b tx_data=%h exp 1/77", tx_start, tx_data); end
        req = '0;
        step(); tx_busy = 1'b1;
        step(); tx_busy = 1'b0;
        step();
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        req_data = 32'h335A_1100;
        @(negedge clk);
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_pre: tx_start=%b exp 0", tx_start); end
        @(negedge clk);
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'h5A || active_id !== 2'd2) begin
            errors++; $display("FAIL single_start: tx_start=%b tx_data=%h id=%0d exp 1/5a/2", tx_start, tx_data, active_id); end
        step();
        @(negedge clk);
        checks++; if (tx_start !== 1'b0 || ack !== 4'b0000) begin errors++; $display("FAIL single_wait: tx_start=%b ack=%b exp 0/0000", tx_start, ack); end
        step();
        tx_busy = 1'b1;
        @(negedge clk);
        checks++; if (ack !== 4'b0100 || active_id !== 2'd2) begin errors++; $display("FAIL single_ack: ack=%b id=%0d exp 0100/2", ack, active_id); end
        step();
        req = '0;
        @(negedge clk);
        checks++; if (ack !== 4'b0000 || tx_data !== 8'h5A) begin errors++; $display("FAIL single_done: ack=%b tx_data=%h exp 0000/5a", ack, tx_data); end
        repeat (9) step();
        tx_busy = 1'b0;
        @(negedge clk);
        checks++; if (active_id !== 2'd2) begin errors++; $display("FAIL single_still_busy: id=%0d exp 2", active_id); end
        step();
        @(negedge clk);
        checks++; if (active_id !== 2'd0 || tx_start !== 1'b0 || ack !== 4'b0000) begin
            errors++; $display("FAIL single_idle: id=%0d tx_start=%b ack=%b exp 0/0/0000", active_id, tx_start, ack); end
    endtask

    task automatic test_round_robin();
        logic [7:0] d;
        logic [1:0] id;
        logic [3:0] a;
        do_reset();
        req = 4'b1111;
        req_data = 32'hA3A2_A1A0;
        for (int j = 0; j < 5; j++) begin
            serve("rr", d, id, a);
            checks++; if (id !== 2'(j % 4) || d !== 8'hA0 + 8'(j % 4) || a !== 4'(1 << (j % 4))) begin
                errors++; $display("FAIL rr_%0d: id=%0d data=%h ack=%b exp %0d/%h/%b", j, id, d, a, j % 4, 8'hA0 + 8'(j % 4), 4'(1 << (j % 4))); end
        end
        req = '0;
        step();
        step();
    endtask

    task automatic test_timeout();
        logic [7:0] d;
        logic [1:0] id;
        logic [3:0] a;
        bit early = 0;
        do_reset();
        req = 4'b0001;
        req_data = 32'h0000_B2B1;
        wait_start("to");
        for (int k = 1; k < T; k++) begin
            @(negedge clk);
            if (timeout_err !== 1'b0 || ack !== 4'b0000) early = 1;
        end
        checks++; if (early) begin errors++; $display("FAIL to_early: timeout_err or ack high before %0d cycles (err=%b ack=%b)", T, timeout_err, ack); end
        @(negedge clk);
        checks++; if (timeout_err !== 1'b1 || ack !== 4'b0000 || active_id !== 2'd0) begin
            errors++; $display("FAIL to_flag: err=%b ack=%b id=%0d exp 1/0000/0", timeout_err, ack, active_id); end
        req = 4'b0011;
        serve("to_next", d, id, a);
        checks++; if (id !== 2'd1 || d !== 8'hB2 || a !== 4'b0010) begin
            errors++; $display("FAIL to_rr_ptr: id=%0d data=%h ack=%b exp 1/b2/0010", id, d, a); end
        serve("to_after", d, id, a);
        checks++; if (id !== 2'd0 || a !== 4'b0001 || timeout_err !== 1'b1) begin
            errors++; $display("FAIL to_sticky: id=%0d ack=%b err=%b exp 0/0001/1", id, a, timeout_err); end
        req = '0;
        step();
        step();
    endtask

    task automatic test_ext_busy();
        bit started = 0;
        do_reset();
        tx_busy = 1'b1;
        req = 4'b0010;
        req_data = 32'h0000_C400;
        repeat (5) begin
            @(negedge clk);
            if (tx_start !== 1'b0) started = 1;
        end
        checks++; if (started) begin errors++; $display("FAIL ext_busy_hold: tx_start=1 exp 0 while tx_busy"); end
        step();
        tx_busy = 1'b0;
        @(negedge clk);
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL ext_busy_same: tx_start=%b exp 0", tx_start); end
        @(negedge clk);
        checks++; if (tx_start !== 1'b1 || active_id !== 2'd1 || tx_data !== 8'hC4) begin
            errors++; $display("FAIL ext_busy_start: tx_start=%b id=%0d data=%h exp 1/1/c4", tx_start, active_id, tx_data); end
        req = '0;
        step(); tx_busy = 1'b1;
        step(); tx_busy = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b1000;
        req_data = 32'hC300_0000;
        wait_start("rm");
        step(); tx_busy = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (tx_start !== 1'b0 || ack !== 4'b0000 || tx_data !== 8'h00 || active_id !== 2'd0 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL rm_async: tx_start=%b ack=%b data=%h id=%0d err=%b exp 0/0000/00/0/0", tx_start, ack, tx_data, active_id, timeout_err); end
        step();
        tx_busy = 1'b0;
        rst_n = 1'b1;
        wait_start("rm_regrant");
        checks++; if (active_id !== 2'd3 || tx_data !== 8'hC3) begin errors++; $display("FAIL rm_regrant: id=%0d data=%h exp 3/c3", active_id, tx_data); end
        req = '0;
        step(); tx_busy = 1'b1;
        step(); tx_busy = 1'b0;
        step();
    endtask

    task automatic test_data_stable();
        do_reset();
        req = 4'b0001;
        req_data = 32'h0000_0011;
        wait_start("ds");
        req_data = 32'h0000_0022;
        req = '0;
        step(); tx_busy = 1'b1;
        @(negedge clk);
        checks++; if (ack !== 4'b0001 || tx_data !== 8'h11) begin errors++; $display("FAIL ds_ack: ack=%b data=%h exp 0001/11", ack, tx_data); end
        step();
        @(negedge clk);
        checks++; if (tx_data !== 8'h11) begin errors++; $display("FAIL ds_done: data=%h exp 11", tx_data); end
        step(); tx_busy = 1'b0;
        @(negedge clk);
        checks++; if (tx_data !== 8'h11 || active_id !== 2'd0) begin errors++; $display("FAIL ds_last: data=%h id=%0d exp 11/0", tx_data, active_id); end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_ext_busy();
        test_reset_mid();
        test_data_stable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
